msg_deframer: RTL and testbench
===============================

MSG_DEFRAMER -- requirements
Module: msg_deframer

Interface
REQ-001 Parameter SOF, default 8'hA5, start-of-frame delimiter byte.
REQ-002 Parameter MSG_BYTES, default 21, payload bytes per frame (payload width = 8*MSG_BYTES = 168 bits).
REQ-003 Parameter TIMEOUT, default 1000, maximum idle cycles allowed between bytes inside a frame.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_data  input  8  received byte from the link receiver.
REQ-007 in_valid  input  1  in_data is valid this cycle; one byte per asserted cycle.
REQ-008 msg  output  168  last accepted payload, feeding the order-book processor message input.
REQ-009 msg_valid  output  1  one-cycle pulse when msg has just been updated.
REQ-010 frames_ok  output  16  count of accepted frames, saturating.
REQ-011 frames_bad  output  16  count of rejected frames (checksum error or timeout), saturating.

Function
REQ-012 Frame format: SOF, then MSG_BYTES payload bytes, then one checksum byte equal to the XOR of all payload bytes.
REQ-013 Payload byte k (0-based, k = 0 first after SOF) maps to msg[8k+7:8k]: byte 0 = type, bytes 1-4 = sequence number (LSB first), byte 5 = side, bytes 10-13 = price, bytes 14-17 = quantity.
REQ-014 States: IDLE, PAYLOAD, CHECK.
REQ-015 IDLE: in_valid with in_data == SOF -> PAYLOAD, byte index 0, running XOR 0; other bytes discarded, no counter change.
REQ-016 PAYLOAD: each in_valid byte stored in a shadow register at the current index; XOR updated; index increments; after byte MSG_BYTES-1 -> CHECK.
REQ-017 A SOF value inside PAYLOAD is payload data, not resynchronisation.
REQ-018 CHECK: on in_valid, if byte == running XOR, copy shadow to msg, pulse msg_valid next cycle, increment frames_ok; else increment frames_bad, msg unchanged; either way -> IDLE.
REQ-019 Latency: msg and msg_valid update on the clock edge after the checksum byte is sampled (1 cycle); msg_valid is high for exactly one cycle.
REQ-020 msg holds its value between accepted frames; a partial or bad frame never alters msg.
REQ-021 Inter-byte timer: in PAYLOAD or CHECK, it counts cycles with in_valid low and clears on in_valid; when it reaches TIMEOUT, abort to IDLE, increment frames_bad.
REQ-022 A byte arriving in the same cycle the timer would reach TIMEOUT is accepted and the timer clears (data wins).
REQ-023 The cycle after CHECK returns to IDLE, a SOF byte is accepted (back-to-back frames, no gap required).
REQ-024 frames_ok and frames_bad stop at 16'hFFFF; no wrap.
REQ-025 The index counter is wide enough for MSG_BYTES-1 and never wraps mid-frame.

Reset
REQ-026 While reset is high at a clock edge: state IDLE, index 0, XOR 0, timer 0, msg 0, msg_valid 0, frames_ok 0, frames_bad 0.
REQ-027 Reset asserted mid-frame discards the partial frame without counting it as bad.
REQ-028 Reset has priority over in_valid in the same cycle.

Verification
REQ-029 SOF, 21 payload bytes 0x00,0x01..0x14, checksum 0x14 -> msg_valid pulses once, msg[7:0]=0x00, msg[15:8]=0x01, frames_ok=1.
REQ-030 Same frame with checksum 0x15 -> no msg_valid, msg unchanged, frames_bad=1.
REQ-031 SOF, 10 bytes, then in_valid low for 1000 cycles -> IDLE, frames_bad=1; a following valid frame is accepted.
REQ-032 Two valid frames back-to-back with no idle cycles -> two msg_valid pulses, frames_ok=2, msg equals the second payload.
REQ-033 Payload containing 0xA5 at byte 3 -> treated as data, frame accepted when the checksum is correct.
REQ-034 Reset pulsed after byte 12 of a frame -> all outputs 0, frames_bad=0; the next full frame is accepted.

Source files
------------

// File: rtl/msg_deframer.sv
// Receive-side deframer: strips SOF/checksum framing from a byte stream and
// presents each verified payload as one wide message with a one-cycle strobe.
module msg_deframer #(
  parameter logic [7:0]  SOF       = 8'hA5,
  parameter int unsigned MSG_BYTES = 21,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic [8*MSG_BYTES-1:0] msg,
  output logic                   msg_valid,
  output logic [15:0]            frames_ok,
  output logic [15:0]            frames_bad
);

  localparam int unsigned MSG_W = 8 * MSG_BYTES;
  localparam int unsigned IDX_W = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [15:0]      CNT_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [7:0]         xor_acc;
  logic [TMR_W-1:0]   timer;
  logic [MSG_W-1:0]   shadow;

  logic               timeout_c;
  logic               store_c;
  logic               accept_c;
  logic               reject_c;

  // Abort fires on the idle cycle that would bring the timer to TIMEOUT;
  // a byte in that same cycle suppresses it.
  assign timeout_c = (state != IDLE) && !in_valid && (timer == TMR_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    store_c   = 1'b0;
    accept_c  = 1'b0;
    reject_c  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && (in_data == SOF)) begin
          state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (in_valid) begin
          store_c = 1'b1;
          if (idx == LAST_IDX) begin
            state_nxt = CHECK;
          end
        end else if (timeout_c) begin
          reject_c  = 1'b1;
          state_nxt = IDLE;
        end
      end
      CHECK: begin
        if (in_valid) begin
          if (in_data == xor_acc) begin
            accept_c = 1'b1;
          end else begin
            reject_c = 1'b1;
          end
          state_nxt = IDLE;
        end else if (timeout_c) begin
          reject_c  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Payload assembly: index and running XOR restart whenever the frame ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx     <= '0;
      xor_acc <= '0;
    end else if (state_nxt == IDLE) begin
      idx     <= '0;
      xor_acc <= '0;
    end else if (store_c) begin
      xor_acc <= xor_acc ^ in_data;
      idx     <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
    end else begin
      for (int unsigned k = 0; k < MSG_BYTES; k++) begin
        if (store_c && (idx == IDX_W'(k))) begin
          shadow[8*k +: 8] <= in_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if ((state == IDLE) || in_valid || timeout_c) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Published message only moves on a verified frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      msg       <= '0;
      msg_valid <= 1'b0;
    end else begin
      msg_valid <= accept_c;
      if (accept_c) begin
        msg <= shadow;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frames_ok  <= '0;
      frames_bad <= '0;
    end else begin
      if (accept_c && (frames_ok != CNT_MAX)) begin
        frames_ok <= frames_ok + 16'd1;
      end
      if (reject_c && (frames_bad != CNT_MAX)) begin
        frames_bad <= frames_bad + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_msg_deframer.sv
// Directed bench for msg_deframer: framing, checksum, timeout, back-to-back
// frames and mid-frame reset, with expected values built in the bench.
module tb_msg_deframer;

  localparam int unsigned MSG_BYTES = 21;
  localparam int unsigned MSG_W     = 8 * MSG_BYTES;
  localparam logic [7:0]  SOF_B     = 8'hA5;

  typedef logic [MSG_W-1:0] msg_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  msg_t        msg;
  logic        msg_valid;
  logic [15:0] frames_ok;
  logic [15:0] frames_bad;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  msg_deframer #(.SOF(SOF_B), .MSG_BYTES(MSG_BYTES), .TIMEOUT(1000)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .msg        (msg),
    .msg_valid  (msg_valid),
    .frames_ok  (frames_ok),
    .frames_bad (frames_bad)
  );

  always #5 clk = ~clk;

  // msg_valid is sampled on the rising edge, so a pulse is tallied one edge late
  always @(posedge clk) begin
    if (msg_valid === 1'b1) pulses++;
  end

  task automatic check(input string tag, input msg_t got, input msg_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic msg_t mk(input logic [7:0] base, input logic [7:0] step);
    msg_t p;
    for (int k = 0; k < int'(MSG_BYTES); k++) begin
      p[8*k +: 8] = base + 8'(step * k);
    end
    return p;
  endfunction

  function automatic logic [7:0] xor_of(input msg_t p);
    logic [7:0] x = 8'h00;
    for (int k = 0; k < int'(MSG_BYTES); k++) x ^= p[8*k +: 8];
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic send_bytes(input msg_t p, input int first, input int last);
    for (int k = first; k <= last; k++) send_byte(p[8*k +: 8]);
  endtask

  task automatic send_frame(input msg_t p, input logic [7:0] ck);
    send_byte(SOF_B);
    send_bytes(p, 0, MSG_BYTES - 1);
    send_byte(ck);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    msg_t pa, pb, pc, pd, pe, pf, pg, ph;
    pa = mk(8'h00, 8'h01);
    pb = mk(8'h40, 8'h03);
    pc = mk(8'h10, 8'h07);
    pd = mk(8'h77, 8'h05);
    pe = mk(8'h01, 8'h09);
    pf = mk(8'hF0, 8'h11);
    pg = mk(8'h20, 8'h02);
    pg[31:24] = SOF_B;
    pg[7:0]   = SOF_B;
    ph = mk(8'h5C, 8'h0D);

    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_msg", msg, '0);
    check("rst_valid", msg_valid, 0);
    check("rst_ok", frames_ok, 0);
    check("rst_bad", frames_bad, 0);
    reset = 1'b0;
    idle(1);

    // Good frame 0x00..0x14, checksum 0x14
    send_frame(pa, 8'h14);
    check("t1_valid", msg_valid, 1);
    check("t1_byte0", msg[7:0], 8'h00);
    check("t1_byte1", msg[15:8], 8'h01);
    check("t1_msg", msg, pa);
    check("t1_ok", frames_ok, 1);
    check("t1_bad", frames_bad, 0);
    idle(1);
    check("t1_pulse_len", msg_valid, 0);
    idle(1);
    check("t1_pulses", pulses, 1);

    // Bad checksums: same payload, then a different payload
    send_frame(pa, 8'h15);
    idle(2);
    check("t2_bad", frames_bad, 1);
    check("t2_ok", frames_ok, 1);
    check("t2_pulses", pulses, 1);
    send_frame(pb, xor_of(pb) ^ 8'h01);
    idle(2);
    check("t2_msg_kept", msg, pa);
    check("t2_bad2", frames_bad, 2);

    // Non-SOF bytes in IDLE are dropped silently
    send_byte(8'h00); send_byte(8'h5A); send_byte(8'hFF);
    idle(2);
    check("t3_ok", frames_ok, 1);
    check("t3_bad", frames_bad, 2);

    // Timeout after 10 payload bytes: 999 idle cycles survive, the 1000th aborts
    send_byte(SOF_B);
    send_bytes(pb, 0, 9);
    idle(999);
    check("t4_pre_timeout", frames_bad, 2);
    idle(1);
    check("t4_timeout", frames_bad, 3);
    send_frame(pc, xor_of(pc));
    idle(2);
    check("t4_next_ok", frames_ok, 2);
    check("t4_next_msg", msg, pc);
    check("t4_bad_same", frames_bad, 3);

    // Byte on the cycle the timer would expire is accepted
    send_byte(SOF_B);
    send_bytes(pd, 0, 4);
    idle(999);
    send_bytes(pd, 5, MSG_BYTES - 1);
    send_byte(xor_of(pd));
    idle(2);
    check("t5_ok", frames_ok, 3);
    check("t5_bad", frames_bad, 3);
    check("t5_msg", msg, pd);

    // Timeout while waiting for the checksum byte
    send_byte(SOF_B);
    send_bytes(pe, 0, MSG_BYTES - 1);
    idle(1000);
    check("t5_check_timeout", frames_bad, 4);
    check("t5_msg_kept", msg, pd);

    // Back-to-back frames
    send_frame(pe, xor_of(pe));
    send_frame(pf, xor_of(pf));
    idle(2);
    check("t6_ok", frames_ok, 5);
    check("t6_pulses", pulses, 5);
    check("t6_msg", msg, pf);

    // SOF value inside payload is data
    send_frame(pg, xor_of(pg));
    idle(2);
    check("t7_ok", frames_ok, 6);
    check("t7_msg", msg, pg);

    // Reset after payload byte 12, with a SOF offered during reset
    send_byte(SOF_B);
    send_bytes(pa, 0, 12);
    reset = 1'b1; in_valid = 1'b1; in_data = SOF_B;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    check("t8_msg", msg, '0);
    check("t8_valid", msg_valid, 0);
    check("t8_ok", frames_ok, 0);
    check("t8_bad", frames_bad, 0);
    send_frame(ph, xor_of(ph));
    idle(2);
    check("t8_next_ok", frames_ok, 1);
    check("t8_next_bad", frames_bad, 0);
    check("t8_next_msg", msg, ph);
    check("t8_pulses", pulses, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
